// File: rtl/scbuf_fbd_ctl.sv
// Fill-buffer controller: allocates 8 entries, sequences 4-beat fills and OFF-mode stores onto the write port, schedules reads.
// Latency: grants are combinational in the request cycle; write/read port controls and fill_done register one cycle later.
// Backpressure: fill beats are never stalled; stores and reads are refused (requester holds) when not grantable.
// Optional protocol checker: define SCBUF_FBD_PROT_CHK_EN to build the sticky prot_err logic.
module scbuf_fbd_ctl #(
  parameter int NENT  = 8,
  parameter int NBEAT = 4
) (
  input  logic        rclk,
  input  logic        rst,
  input  logic        alloc_req,
  output logic        alloc_gnt,
  output logic [2:0]  alloc_id,
  output logic        fb_full,
  input  logic        dram_fill_vld,
  input  logic [2:0]  dram_fill_id,
  input  logic        st_req,
  input  logic [2:0]  st_id,
  input  logic [2:0]  st_dw,
  output logic        st_gnt,
  input  logic        rd_req,
  input  logic [2:0]  rd_id,
  input  logic        rd_last,
  output logic        rd_gnt,
  output logic        fill_done,
  output logic [2:0]  fill_done_id,
  output logic [15:0] sctag_scbuf_fbwr_wen_r2,
  output logic [2:0]  sctag_scbuf_fbwr_wl_r2,
  output logic        sctag_scbuf_fbd_stdatasel_c3,
  output logic        sctag_scbuf_fbrd_en_c3,
  output logic [2:0]  sctag_scbuf_fbrd_wl_c3,
  output logic        prot_err
);

  localparam int CW = $clog2(NBEAT);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_READY = 2'd2
  } ent_state_e;

  ent_state_e      state_q [NENT];
  ent_state_e      state_d [NENT];
  logic [CW-1:0]   cnt_q   [NENT];
  logic [CW-1:0]   cnt_d   [NENT];
  logic [NENT-1:0] free_vec;

  logic [CW-1:0]   beat_cnt;
  logic            beat_last;
  logic            fill_adv;
  logic [15:0]     beat_wen;
  logic [15:0]     st_wen;

  // Free-entry vector feeds allocation and the full flag.
  always_comb begin
    free_vec = '0;
    for (int i = 0; i < NENT; i++) begin
      free_vec[i] = (state_q[i] == ST_FREE);
    end
  end

  // Lowest-numbered free entry wins; scanning downward leaves the lowest match last.
  always_comb begin
    alloc_id = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_id = 3'(i);
    end
  end

  assign fb_full   = ~|free_vec;
  assign alloc_gnt = alloc_req & ~fb_full;

  // Fill beats own the write port; a store only gets it in a beat-free cycle.
  assign st_gnt = st_req & ~dram_fill_vld & (state_q[st_id] != ST_FREE);
  // An entry completing this cycle is still ALLOC, so a same-cycle read is refused.
  assign rd_gnt = rd_req & (state_q[rd_id] == ST_READY);

  assign beat_cnt  = cnt_q[dram_fill_id];
  assign beat_last = (beat_cnt == CW'(NBEAT - 1));
  // Beats to non-ALLOC entries are still written but never advance entry state.
  assign fill_adv  = dram_fill_vld & (state_q[dram_fill_id] == ST_ALLOC);
  assign beat_wen  = 16'h000F << {beat_cnt, 2'b00};
  assign st_wen    = 16'h0003 << {st_dw, 1'b0};

  // Per-entry next state: grant, beat progress and last-read free target disjoint entry states.
  always_comb begin
    for (int i = 0; i < NENT; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (alloc_gnt && (alloc_id == 3'(i))) begin
        state_d[i] = ST_ALLOC;
        cnt_d[i]   = '0;
      end
      if (fill_adv && (dram_fill_id == 3'(i))) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
        if (beat_last) state_d[i] = ST_READY;
      end
      if (rd_gnt && rd_last && (rd_id == 3'(i))) begin
        state_d[i] = ST_FREE;
      end
    end
  end

  // Entry state and beat counter registers.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        state_q[i] <= ST_FREE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NENT; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Write-port controls; wordline holds across idle cycles.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      sctag_scbuf_fbwr_wen_r2      <= '0;
      sctag_scbuf_fbwr_wl_r2       <= '0;
      sctag_scbuf_fbd_stdatasel_c3 <= 1'b0;
    end else if (dram_fill_vld) begin
      sctag_scbuf_fbwr_wen_r2      <= beat_wen;
      sctag_scbuf_fbwr_wl_r2       <= dram_fill_id;
      sctag_scbuf_fbd_stdatasel_c3 <= 1'b0;
    end else if (st_gnt) begin
      sctag_scbuf_fbwr_wen_r2      <= st_wen;
      sctag_scbuf_fbwr_wl_r2       <= st_id;
      sctag_scbuf_fbd_stdatasel_c3 <= 1'b1;
    end else begin
      sctag_scbuf_fbwr_wen_r2      <= '0;
      sctag_scbuf_fbd_stdatasel_c3 <= 1'b0;
    end
  end

  // Read-port controls; wordline holds when no read issues.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      sctag_scbuf_fbrd_en_c3 <= 1'b0;
      sctag_scbuf_fbrd_wl_c3 <= '0;
    end else begin
      sctag_scbuf_fbrd_en_c3 <= rd_gnt;
      if (rd_gnt) sctag_scbuf_fbrd_wl_c3 <= rd_id;
    end
  end

  // Completion pulse lands in the same cycle the entry first reads READY.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      fill_done    <= 1'b0;
      fill_done_id <= '0;
    end else begin
      fill_done <= fill_adv & beat_last;
      if (fill_adv && beat_last) fill_done_id <= dram_fill_id;
    end
  end

`ifdef SCBUF_FBD_PROT_CHK_EN
  logic prot_viol;

  // Illegal accesses; store/read rejection already falls out of the grant terms.
  assign prot_viol = (dram_fill_vld & (state_q[dram_fill_id] != ST_ALLOC))
                   | (st_req & (state_q[st_id] == ST_FREE))
                   | (rd_req & (state_q[rd_id] == ST_FREE));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) prot_err <= 1'b0;
    else if (prot_viol) prot_err <= 1'b1;
  end
`else
  assign prot_err = 1'b0;
`endif

endmodule
